// File: rtl/pwm_spi_config_bridge.sv
// SPI mode-0 slave bridge: 16-bit frames become register-file write strobes or read-back on MISO.
// Pin edges act 3 i_clk cycles later; strobe 4 cycles after the 16th sclk rise; no backpressure (host paces sclk).
module pwm_spi_config_bridge #(
    parameter int ADDRESS_WIDTH = 6,
    parameter int DATA_WIDTH    = 8
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic                     i_sclk,
    input  logic                     i_cs_n,
    input  logic                     i_mosi,
    output logic                     o_miso,
    output logic                     o_miso_oe,
    output logic                     o_write_en,
    output logic [ADDRESS_WIDTH-1:0] o_address,
    output logic [DATA_WIDTH-1:0]    o_data,
    input  logic [DATA_WIDTH-1:0]    i_rdata,
    output logic                     o_frame_err,
    output logic                     o_busy
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        COMMIT,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic sclk_s1, sclk_s2, sclk_prev;
    logic cs_s1, cs_s2, cs_prev;
    logic mosi_s1, mosi_s2;

    logic sclk_rise;
    logic sclk_fall;
    logic cs_fall;
    logic abort;

    logic [4:0]            bit_cnt;
    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] tx;
    logic                  rw_write;
    logic                  skip_fall;
    logic [1:0]            load_pend;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sclk_s1   <= 1'b0;
            sclk_s2   <= 1'b0;
            sclk_prev <= 1'b0;
            cs_s1     <= 1'b1;
            cs_s2     <= 1'b1;
            cs_prev   <= 1'b1;
            mosi_s1   <= 1'b0;
            mosi_s2   <= 1'b0;
        end else begin
            sclk_s1   <= i_sclk;
            sclk_s2   <= sclk_s1;
            sclk_prev <= sclk_s2;
            cs_s1     <= i_cs_n;
            cs_s2     <= cs_s1;
            cs_prev   <= cs_s2;
            mosi_s1   <= i_mosi;
            mosi_s2   <= mosi_s1;
        end
    end

    assign sclk_rise = sclk_s2 & ~sclk_prev;
    assign sclk_fall = ~sclk_s2 & sclk_prev;
    assign cs_fall   = ~cs_s2 & cs_prev;
    // cs_n is checked as a level so a release that lands during COMMIT is still seen in DONE.
    assign abort     = ((state == ADDR) || (state == DATA)) && cs_s2;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    state_next = ADDR;
                end
            end
            ADDR: begin
                if (cs_s2) begin
                    state_next = IDLE;
                end else if (sclk_rise && (bit_cnt == 5'd7)) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (cs_s2) begin
                    state_next = IDLE;
                end else if (sclk_rise && (bit_cnt == 5'd15)) begin
                    state_next = rw_write ? COMMIT : DONE;
                end
            end
            COMMIT: begin
                state_next = DONE;
            end
            DONE: begin
                if (cs_s2) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            bit_cnt     <= 5'd0;
            shreg       <= '0;
            tx          <= '0;
            rw_write    <= 1'b0;
            skip_fall   <= 1'b0;
            load_pend   <= 2'b00;
            o_address   <= '0;
            o_data      <= '0;
            o_write_en  <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            o_write_en  <= (state == COMMIT);
            o_frame_err <= abort;
            load_pend   <= {load_pend[0], 1'b0};
            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        bit_cnt <= 5'd0;
                    end
                end
                ADDR: begin
                    if (!cs_s2 && sclk_rise) begin
                        shreg   <= {shreg[DATA_WIDTH-2:0], mosi_s2};
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd7) begin
                            o_address    <= {shreg[ADDRESS_WIDTH-2:0], mosi_s2};
                            rw_write     <= shreg[6];
                            load_pend[0] <= ~shreg[6];
                            skip_fall    <= 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (!cs_s2) begin
                        if (sclk_rise) begin
                            shreg   <= {shreg[DATA_WIDTH-2:0], mosi_s2};
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                        // The fall right after the 8th rise must not shift: MISO already presents bit 7.
                        if (sclk_fall && !rw_write) begin
                            if (skip_fall) begin
                                skip_fall <= 1'b0;
                            end else begin
                                tx <= {tx[DATA_WIDTH-2:0], 1'b0};
                            end
                        end
                    end
                end
                COMMIT: begin
                    o_data <= shreg;
                end
                default: begin
                end
            endcase
            // Read data is sampled two cycles after the address moves, giving i_rdata time to settle.
            if (load_pend[1]) begin
                tx <= i_rdata;
            end
        end
    end

    assign o_miso_oe = ((state == DATA) || (state == DONE)) && !rw_write;
    assign o_miso    = o_miso_oe & tx[DATA_WIDTH-1];
    assign o_busy    = (state != IDLE);

endmodule

// File: tb/tb_pwm_spi_config_bridge.sv
// Directed bench for pwm_spi_config_bridge: drives SPI frames and checks strobes, read-back and aborts.
module tb_pwm_spi_config_bridge;

    logic       i_clk = 1'b0;
    logic       i_reset_n = 1'b0;
    logic       i_sclk = 1'b0;
    logic       i_cs_n = 1'b1;
    logic       i_mosi = 1'b0;
    logic       o_miso;
    logic       o_miso_oe;
    logic       o_write_en;
    logic [5:0] o_address;
    logic [7:0] o_data;
    logic [7:0] i_rdata;
    logic       o_frame_err;
    logic       o_busy;

    int n_cmp = 0;
    int n_err = 0;

    int         wr_cnt = 0;
    int         fe_cnt = 0;
    logic [5:0] wa_q[$];
    logic [7:0] wd_q[$];

    logic [7:0] rx;
    logic       oe_data_all;
    logic       oe_addr_any;
    int         snap_wr;
    int         snap_fe;

    pwm_spi_config_bridge #(
        .ADDRESS_WIDTH(6),
        .DATA_WIDTH   (8)
    ) dut (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_sclk     (i_sclk),
        .i_cs_n     (i_cs_n),
        .i_mosi     (i_mosi),
        .o_miso     (o_miso),
        .o_miso_oe  (o_miso_oe),
        .o_write_en (o_write_en),
        .o_address  (o_address),
        .o_data     (o_data),
        .i_rdata    (i_rdata),
        .o_frame_err(o_frame_err),
        .o_busy     (o_busy)
    );

    always #5 i_clk = ~i_clk;

    // Register-file model: only address 0x12 holds a distinctive value.
    always_comb begin
        i_rdata = 8'h00;
        if (o_address == 6'h12) begin
            i_rdata = 8'hC3;
        end
    end

    always @(negedge i_clk) begin
        if (o_write_en) begin
            wr_cnt++;
            wa_q.push_back(o_address);
            wd_q.push_back(o_data);
        end
        if (o_frame_err) begin
            fe_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wcyc(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    // Shifts nbits MSB-first from frm[23]; data-phase MISO is sampled just before each rise.
    task automatic send_frame(input logic [23:0] frm, input int nbits, input int half,
                              input bit end_cs, input int gap);
        rx          = 8'h00;
        oe_data_all = 1'b1;
        oe_addr_any = 1'b0;
        @(negedge i_clk);
        i_cs_n = 1'b0;
        wcyc(half);
        for (int i = 0; i < nbits; i++) begin
            i_mosi = frm[23-i];
            wcyc(half);
            if (i >= 8 && i < 16) begin
                rx          = {rx[6:0], o_miso};
                oe_data_all = oe_data_all & o_miso_oe;
            end else if (i < 8) begin
                oe_addr_any = oe_addr_any | o_miso_oe;
            end
            i_sclk = 1'b1;
            wcyc(half);
            i_sclk = 1'b0;
        end
        if (end_cs) begin
            wcyc(half);
            i_cs_n = 1'b1;
            i_mosi = 1'b0;
            wcyc(gap);
        end
    endtask

    initial begin
        // Reset state
        wcyc(3);
        check("rst_write_en", o_write_en, 1'b0);
        check("rst_frame_err", o_frame_err, 1'b0);
        check("rst_busy", o_busy, 1'b0);
        check("rst_miso", o_miso, 1'b0);
        check("rst_miso_oe", o_miso_oe, 1'b0);
        check("rst_address", o_address, 6'h00);
        check("rst_data", o_data, 8'h00);
        i_reset_n = 1'b1;
        wcyc(5);

        // Write 0x5A to 0x05
        send_frame({16'h855A, 8'h00}, 16, 5, 1'b1, 10);
        check("wr_count", wr_cnt, 1);
        check("wr_addr", wa_q[0], 6'h05);
        check("wr_data", wd_q[0], 8'h5A);
        check("wr_no_err", fe_cnt, 0);
        check("wr_data_hold", o_data, 8'h5A);
        check("wr_idle_busy", o_busy, 1'b0);

        // Read address 0x12, expecting 0xC3 on MISO
        send_frame({16'h1200, 8'h00}, 16, 5, 1'b1, 10);
        check("rd_miso_bits", rx, 8'hC3);
        check("rd_address", o_address, 6'h12);
        check("rd_oe_data", oe_data_all, 1'b1);
        check("rd_oe_addr", oe_addr_any, 1'b0);
        check("rd_oe_after", o_miso_oe, 1'b0);
        check("rd_no_strobe", wr_cnt, 1);
        check("rd_no_err", fe_cnt, 0);

        // Abort a write to 0x2A after 11 bits
        send_frame({16'hAA77, 8'h00}, 11, 5, 1'b1, 10);
        check("ab_err", fe_cnt, 1);
        check("ab_no_strobe", wr_cnt, 1);
        check("ab_busy", o_busy, 1'b0);
        check("ab_addr_kept", o_address, 6'h2A);

        // Recovery write 0xFF to 0x01
        send_frame({16'h81FF, 8'h00}, 16, 5, 1'b1, 10);
        check("rec_count", wr_cnt, 2);
        check("rec_addr", wa_q[1], 6'h01);
        check("rec_data", wd_q[1], 8'hFF);
        check("rec_no_err", fe_cnt, 1);

        // Overlong frame: write 0xA5 to 0x3F plus 8 junk bits
        send_frame({16'hBFA5, 8'h3C}, 24, 5, 1'b1, 10);
        check("long_count", wr_cnt, 3);
        check("long_addr", wa_q[2], 6'h3F);
        check("long_data", wd_q[2], 8'hA5);
        check("long_no_err", fe_cnt, 1);

        // Reset after 12 bits of a write to 0x0C
        send_frame({16'h8C33, 8'h00}, 12, 5, 1'b0, 0);
        check("mid_busy", o_busy, 1'b1);
        snap_wr = wr_cnt;
        snap_fe = fe_cnt;
        @(negedge i_clk);
        #2 i_reset_n = 1'b0;
        #1;
        check("mid_rst_address", o_address, 6'h00);
        check("mid_rst_data", o_data, 8'h00);
        check("mid_rst_busy", o_busy, 1'b0);
        check("mid_rst_oe", o_miso_oe, 1'b0);
        check("mid_rst_we", o_write_en, 1'b0);
        i_cs_n = 1'b1;
        i_mosi = 1'b0;
        wcyc(3);
        i_reset_n = 1'b1;
        wcyc(8);
        check("mid_no_strobe", wr_cnt, snap_wr);
        check("mid_no_err", fe_cnt, snap_fe);

        // Post-reset write 0x11 to 0x07
        send_frame({16'h8711, 8'h00}, 16, 5, 1'b1, 10);
        check("post_count", wr_cnt, 4);
        check("post_addr", wa_q[3], 6'h07);
        check("post_data", wd_q[3], 8'h11);

        // Back-to-back writes at f_clk/8 with 4-cycle gaps
        send_frame({16'h8010, 8'h00}, 16, 4, 1'b1, 4);
        send_frame({16'h8120, 8'h00}, 16, 4, 1'b1, 4);
        send_frame({16'h8230, 8'h00}, 16, 4, 1'b1, 10);
        check("b2b_count", wr_cnt, 7);
        check("b2b_addr0", wa_q[4], 6'h00);
        check("b2b_data0", wd_q[4], 8'h10);
        check("b2b_addr1", wa_q[5], 6'h01);
        check("b2b_data1", wd_q[5], 8'h20);
        check("b2b_addr2", wa_q[6], 6'h02);
        check("b2b_data2", wd_q[6], 8'h30);
        check("b2b_no_err", fe_cnt, snap_fe);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
